// File: rtl/ps2_scancode_sequencer.sv
// ps2_scancode_sequencer: folds PS/2 set-2 E0/F0 prefixes from the scan-code FIFO into key events
//
// Parameters:
//   EMIT_BREAKS     1: forward break events, 0: drop them silently
//   PREFIX_TIMEOUT  idle cycles a pending prefix survives before it is discarded as an error
//   TO_W            prefix timer width, must hold PREFIX_TIMEOUT
// Ports:
//   sys_clk_i     system clock
//   rst_n_i       asynchronous active-low reset
//   fifo_empty_i  scan-code FIFO empty flag
//   fifo_data_i   FIFO read data, valid the cycle after a pop
//   fifo_r_en_o   FIFO pop strobe
//   key_valid_o   event available, held until accepted
//   key_ready_i   consumer accepts when valid and ready
//   key_code_o    code byte without prefixes
//   key_ext_o     event carried an E0 prefix
//   key_break_o   event carried an F0 prefix
//   err_pulse_o   one-cycle pulse per protocol error or prefix timeout
//   err_count_o   saturating error count
module ps2_scancode_sequencer #(
  parameter bit EMIT_BREAKS    = 1'b0,
  parameter int PREFIX_TIMEOUT = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic       sys_clk_i,
  input  logic       rst_n_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_r_en_o,
  output logic       key_valid_o,
  input  logic       key_ready_i,
  output logic [7:0] key_code_o,
  output logic       key_ext_o,
  output logic       key_break_o,
  output logic       err_pulse_o,
  output logic [7:0] err_count_o
);
  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;
  state_t state_q, state_d;
  logic ext_q, ext_d, brk_q, brk_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic [7:0] code_q, code_d;
  logic kext_q, kext_d, kbrk_q, kbrk_d;
  logic [7:0] err_q, err_d;
  logic expire, err_byte, drop_break;
  // a prefix only ages while it is pending; expiry takes priority over a pop
  assign expire     = (ext_q | brk_q) && timer_q == TO_W'(PREFIX_TIMEOUT - 1);
  assign err_byte   = fifo_data_i == 8'h00 || fifo_data_i == 8'hFF;
  assign drop_break = brk_q && !EMIT_BREAKS;
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      timer_q <= '0;
      code_q  <= 8'h00;
      kext_q  <= 1'b0;
      kbrk_q  <= 1'b0;
      err_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      kext_q  <= kext_d;
      kbrk_q  <= kbrk_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    timer_d = timer_q;
    code_d  = code_q;
    kext_d  = kext_q;
    kbrk_d  = kbrk_q;
    err_d   = (err_pulse_o && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    case (state_q)
      IDLE: begin
        if (expire) begin
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          timer_d = '0;
        end else if (!fifo_empty_i) begin
          state_d = READ;
        end else if (ext_q | brk_q) begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      READ: begin
        timer_d = '0;
        state_d = IDLE;
        if (fifo_data_i == 8'hE0) begin
          ext_d = 1'b1;
        end else if (fifo_data_i == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (!err_byte && !drop_break) begin
            code_d  = fifo_data_i;
            kext_d  = ext_q;
            kbrk_d  = brk_q;
            state_d = HOLD;
          end
        end
      end
      HOLD: state_d = key_ready_i ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // pop is gated by reset so a non-empty FIFO cannot be popped while held in reset
  always_comb begin
    fifo_r_en_o = rst_n_i && state_q == IDLE && !expire && !fifo_empty_i;
    err_pulse_o = (state_q == IDLE && expire) || (state_q == READ && err_byte);
    key_valid_o = state_q == HOLD;
  end
  assign key_code_o  = code_q;
  assign key_ext_o   = kext_q;
  assign key_break_o = kbrk_q;
  assign err_count_o = err_q;
endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// tb_ps2_scancode_sequencer: directed bench with a transaction-level key-event model
module tb_ps2_scancode_sequencer;
  localparam int PT = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic f_empty = 1'b1;
  logic [7:0] f_data = 8'h00;
  logic r_en, kv, kr = 1'b0, ke, kb, ep;
  logic [7:0] kc, ec;
  logic n_empty = 1'b1;
  logic [7:0] n_data = 8'h00;
  logic n_ren, n_kv, n_ke, n_kb, n_ep;
  logic [7:0] n_kc, n_ec;
  logic [7:0] q[$], nq[$];
  logic [9:0] exp_q[$];
  int checks = 0, failures = 0;
  int err_seen = 0, ren_cnt = 0, ev_cnt = 0, n_events = 0;
  logic [9:0] last_ev = '0, n_last = '0;
  logic m_ext = 1'b0, m_brk = 1'b0;
  int m_err = 0;
  logic prev_hold = 1'b0;
  logic [9:0] held = '0;
  ps2_scancode_sequencer #(.EMIT_BREAKS(1'b1), .PREFIX_TIMEOUT(PT), .TO_W(5)) u_dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .fifo_empty_i(f_empty), .fifo_data_i(f_data),
    .fifo_r_en_o(r_en), .key_valid_o(kv), .key_ready_i(kr), .key_code_o(kc),
    .key_ext_o(ke), .key_break_o(kb), .err_pulse_o(ep), .err_count_o(ec));
  ps2_scancode_sequencer #(.EMIT_BREAKS(1'b0), .PREFIX_TIMEOUT(PT), .TO_W(5)) u_nb (
    .sys_clk_i(clk), .rst_n_i(rst_n), .fifo_empty_i(n_empty), .fifo_data_i(n_data),
    .fifo_r_en_o(n_ren), .key_valid_o(n_kv), .key_ready_i(1'b1), .key_code_o(n_kc),
    .key_ext_o(n_ke), .key_break_o(n_kb), .err_pulse_o(n_ep), .err_count_o(n_ec));
  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask
  always @(posedge clk) begin
    if (r_en && q.size() > 0) f_data <= q.pop_front();
    f_empty <= q.size() == 0;
  end
  always @(posedge clk) begin
    if (n_ren && nq.size() > 0) n_data <= nq.pop_front();
    n_empty <= nq.size() == 0;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      err_seen = 0;
      prev_hold = 1'b0;
    end else begin
      if (r_en) begin
        ren_cnt++;
        chk("underflow", int'(f_empty), 0);
      end
      chk("err_count_vs_pulses", int'(ec), err_seen > 255 ? 255 : err_seen);
      if (prev_hold) begin
        chk("hold_valid", int'(kv), 1);
        chk("hold_stable", int'({kc, ke, kb}), int'(held));
      end
      if (kv && kr) begin
        ev_cnt++;
        last_ev = {kc, ke, kb};
        if (exp_q.size() == 0) chk("unexpected_event", int'({kc, ke, kb}), -1);
        else chk("event", int'({kc, ke, kb}), int'(exp_q.pop_front()));
      end
      prev_hold = kv && !kr;
      held = {kc, ke, kb};
      if (ep) err_seen++;
      if (n_ren) chk("n_underflow", int'(n_empty), 0);
      if (n_kv) begin
        n_events++;
        n_last = {n_kc, n_ke, n_kb};
      end
    end
  end
  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #2;
    q.push_back(b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (b == 8'h00 || b == 8'hFF) m_err = m_err < 255 ? m_err + 1 : 255;
      else exp_q.push_back({b, m_ext, m_brk});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask
  task automatic m_timeout();
    if (m_ext | m_brk) m_err = m_err < 255 ? m_err + 1 : 255;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while (!(q.size() == 0 && exp_q.size() == 0 && !kv && f_empty) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk(nm, 0, 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic wait_kv(input string nm);
    int n = 0;
    while (!kv && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(kv), 1);
  endtask
  task automatic set_ready(input logic v);
    @(posedge clk);
    #2;
    kr = v;
  endtask
  initial begin
    int lat, n, snap, ev0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(kv), 0);
    chk("rst_ren", int'(r_en), 0);
    chk("rst_err", int'({ep, ec}), 0);
    chk("rst_key", int'({kc, ke, kb}), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    // single make code, latency and one pop
    ren_cnt = 0;
    send(8'h2C);
    n = 0;
    while (f_empty && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = 0;
    while (!kv && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 2);
    chk("t1_pops", ren_cnt, 1);
    chk("t1_key", int'({kc, ke, kb}), int'({8'h2C, 2'b00}));
    set_ready(1'b1);
    drain("t1_drain");
    chk("t1_last", int'(last_ev), int'({8'h2C, 2'b00}));
    // extended break with and without break forwarding
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    drain("t2_drain");
    chk("t2_last", int'(last_ev), int'({8'h75, 2'b11}));
    chk("t2_err", int'(ec), 0);
    nq.push_back(8'hE0);
    nq.push_back(8'hF0);
    nq.push_back(8'h75);
    repeat (20) @(negedge clk);
    chk("nb_events", n_events, 0);
    chk("nb_err", int'(n_ec), 0);
    nq.push_back(8'h29);
    repeat (10) @(negedge clk);
    chk("nb_make_events", n_events, 1);
    chk("nb_make", int'(n_last), int'({8'h29, 2'b00}));
    // backpressure with three bytes queued
    set_ready(1'b0);
    send(8'h1C);
    send(8'h32);
    send(8'h21);
    wait_kv("t3_valid");
    snap = ren_cnt;
    repeat (10) @(negedge clk);
    chk("t3_no_pop", ren_cnt - snap, 0);
    chk("t3_hold", int'({kv, kc}), int'({1'b1, 8'h1C}));
    chk("t3_queued", q.size(), 2);
    set_ready(1'b1);
    drain("t3_drain");
    chk("t3_last", int'(last_ev), int'({8'h21, 2'b00}));
    // dangling prefix times out
    send(8'hE0);
    drain("t4_drain");
    repeat (PT + 4) @(negedge clk);
    m_timeout();
    chk("t4_err_count", int'(ec), 1);
    chk("t4_model", int'(ec), m_err);
    chk("t4_pulses", err_seen, 1);
    send(8'h1B);
    drain("t4b_drain");
    chk("t4_after", int'(last_ev), int'({8'h1B, 2'b00}));
    // error codes and saturation
    ev0 = ev_cnt;
    send(8'hFF);
    send(8'h00);
    drain("t5_drain");
    chk("t5_err_count", int'(ec), 3);
    chk("t5_no_event", ev_cnt - ev0, 0);
    for (int i = 0; i < 300; i++) send(8'hFF);
    drain("t5b_drain");
    chk("t5_saturate", int'(ec), 255);
    chk("t5_model", int'(ec), m_err);
    // reset while holding an event
    set_ready(1'b0);
    send(8'h2C);
    send(8'h4B);
    wait_kv("t6_valid");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", int'(kv), 0);
    chk("t6_err", int'(ec), 0);
    chk("t6_ren", int'(r_en), 0);
    chk("t6_key", int'({kc, ke, kb}), 0);
    void'(exp_q.pop_front());
    m_err = 0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    kr = 1'b1;
    drain("t6_drain");
    chk("t6_next", int'(last_ev), int'({8'h4B, 2'b00}));
    chk("t6_model_err", int'(ec), m_err);
    chk("exp_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
